inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of 32-bit words in the target instruction memory.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning width of the write address (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a load session; sampled only in IDLE or DONE.
REQ-006 SHALL have port num_words  input  ADDR_W+1  words to load; legal range 1..DEPTH; latched when start is accepted.
REQ-007 SHALL have port byte_in  input  8  serial program byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  one-cycle write strobe to the instruction memory.
REQ-011 SHALL have port wr_addr  output  ADDR_W  word address of the write.
REQ-012 SHALL have port wr_data  output  32  instruction word to write.
REQ-013 SHALL have port busy  output  1  high in LOAD.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port err  output  1  sticky; set by an illegal num_words.
REQ-016 SHALL have port checksum  output  32  XOR of all words written in the current session.

Function
REQ-017 SHALL implement an FSM with states IDLE, LOAD and DONE.
REQ-018 SHALL, in IDLE or DONE with start=1, latch num_words and clear checksum, word counter, byte counter and err.
REQ-019 SHALL, on a start with legal num_words, enter LOAD on the next cycle.
REQ-020 SHALL, on a start with num_words equal to 0 or greater than DEPTH, set err=1, perform no write, and go to or stay in IDLE.
REQ-021 SHALL drive byte_ready=1 in LOAD only, with no stall cycles, including the cycle in which wr_en is high.
REQ-022 SHALL count a byte as accepted only on a rising edge where byte_valid=1 and byte_ready=1; byte_valid outside LOAD is ignored.
REQ-023 SHALL assemble bytes big-endian: the first accepted byte of a word becomes wr_data[31:24] and the fourth becomes wr_data[7:0].
REQ-024 SHALL assert wr_en for exactly one cycle, in the cycle after the 4th byte of a word is accepted, with wr_addr equal to the word index (0, 1, 2, ...).
REQ-025 SHALL keep wr_data and wr_addr stable while wr_en=1 and hold their last values otherwise.
REQ-026 SHALL update checksum to checksum XOR the new word in the same cycle that wr_en is asserted.
REQ-027 SHALL accept the next word's first byte in the same cycle as the previous word's wr_en without corrupting either word.
REQ-028 SHALL, when the byte completing word num_words-1 is accepted, leave LOAD for DONE, so the final wr_en occurs in the first DONE cycle.
REQ-029 SHALL never write an address at or above num_words and shall not wrap wr_addr within a session.
REQ-030 SHALL hold DONE, with done=1 and checksum stable, until start or rst; a new start in DONE follows REQ-018..020.
REQ-031 SHALL ignore start while in LOAD, with no effect on counters or outputs.
REQ-032 SHALL keep a partial word (1-3 bytes received) pending indefinitely while byte_valid stays low; there is no timeout.

Reset
REQ-033 SHALL, on rst=1 at a rising edge, go to IDLE and set byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, checksum=0, and clear all counters.
REQ-034 SHALL, on rst mid-LOAD, discard any partial word without writing it, and shall assert no wr_en in the cycle after the rst edge.
REQ-035 SHALL give rst priority over start and byte_valid when they occur in the same cycle.

Verification
REQ-036 Single word: start with num_words=1; bytes 0x20,0x01,0x00,0x01 -> one wr_en with addr 0, data 0x20010001; done=1; checksum=0x20010001.
REQ-037 Back-to-back: num_words=3 with byte_valid held high for 12 cycles -> wr_en at addr 0,1,2, data correct; byte_ready never drops in LOAD; done=1 after the third write.
REQ-038 Gapped bytes: random byte_valid gaps on num_words=2 -> same wr_data as the gap-free case; exactly 2 wr_en pulses.
REQ-039 Illegal length: start with num_words=0, then with num_words=17 -> err=1, no wr_en, state IDLE; a following legal start clears err.
REQ-040 Reset mid-word: rst after 2 bytes of word 1 -> no wr_en for word 1; all outputs at reset values; a fresh load rewrites from addr 0.
REQ-041 Start ignored: start pulsed during LOAD with num_words=16 -> session continues; 16 writes; checksum equals the XOR of all 16 words.

Source files
------------

// File: rtl/inst_loader.sv
// Serial instruction loader: packs a big-endian byte stream into 32-bit words
// and writes them to an instruction memory, keeping a running XOR checksum.
module inst_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_WORD  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       partial;

  logic              accept;
  logic              last_word;
  logic              bad_len;
  logic [31:0]       new_word;

  assign accept    = byte_valid & byte_ready;
  assign last_word = (word_cnt + ONE_WORD) == n_words;
  assign bad_len   = (num_words == '0) || (num_words > MAX_WORDS);
  assign new_word  = {partial, byte_in};

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      n_words    <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      partial    <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            n_words  <= num_words;
            word_cnt <= '0;
            byte_cnt <= '0;
            partial  <= '0;
            checksum <= '0;
            done     <= 1'b0;
            if (bad_len) begin
              err        <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
            end else begin
              err        <= 1'b0;
              state      <= LOAD;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Fourth byte completes the word; the next word's first byte
              // may be accepted while this write strobe is high.
              wr_en    <= 1'b1;
              wr_addr  <= word_cnt[ADDR_W-1:0];
              wr_data  <= new_word;
              checksum <= checksum ^ new_word;
              word_cnt <= word_cnt + ONE_WORD;
              if (last_word) begin
                state      <= DONE;
                busy       <= 1'b0;
                byte_ready <= 1'b0;
                done       <= 1'b1;
              end
            end else begin
              partial <= {partial[15:0], byte_in};
            end
          end
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of single-word loads plus hand-written
// multi-word, gapped, illegal-length, reset and ignored-start sequences.
module tb_inst_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       checksum;

  inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_words  (num_words),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Write-port monitor, sampled on the falling edge.
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [31:0] chk_q[$];
  logic [31:0] done_q[$];
  int          ready_drops   = 0;
  int          double_pulses = 0;
  logic        prev_wr       = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      addr_q.push_back(32'(wr_addr));
      data_q.push_back(wr_data);
      chk_q.push_back(checksum);
      done_q.push_back(32'(done));
    end
    if (busy && !byte_ready) ready_drops <= ready_drops + 1;
    if (wr_en && prev_wr)    double_pulses <= double_pulses + 1;
    prev_wr <= wr_en;
  end

  logic [31:0] tx_words[DEPTH];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [ADDR_W:0] n);
    num_words = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Present one byte and hold it until the edge that accepts it.
  task automatic send_byte(input logic [7:0] b, input logic with_start);
    int waited;
    waited     = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    if (with_start) begin
      start     = 1'b1;
      num_words = 5'd1;
    end
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("byte_ready_wait", 32'(byte_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_words(input int n, input bit gaps, input int start_at);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = tx_words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8], (i*4 + k) == start_at);
        if (gaps) begin
          byte_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic verify_session(input string tag, input int mark, input int n);
    logic [31:0] run;
    int          got;
    run = '0;
    got = data_q.size() - mark;
    check({tag, "_pulses"}, 32'(got), 32'(n));
    if (got == n) begin
      for (int i = 0; i < n; i++) begin
        run = run ^ tx_words[i];
        check($sformatf("%s_addr%0d", tag, i), addr_q[mark+i], 32'(i));
        check($sformatf("%s_data%0d", tag, i), data_q[mark+i], tx_words[i]);
        check($sformatf("%s_chk%0d", tag, i), chk_q[mark+i], run);
        check($sformatf("%s_done_at_wr%0d", tag, i), done_q[mark+i], 32'(i == n-1));
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_checksum"}, checksum, run);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_wr_en"},      32'(wr_en),      32'd0);
    check({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
    check({tag, "_wr_data"},    wr_data,         32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_checksum"},   checksum,        32'd0);
  endtask

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int mark;
    logic [31:0] exp_xor;

    vecs[0] = '{8'h20, 8'h01, 8'h00, 8'h01, 32'h2001_0001};
    vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEAD_BEEF};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'hFF00_FF00};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678};

    rst = 1'b1; start = 1'b0; num_words = '0; byte_in = '0; byte_valid = 1'b0;
    tick(3);
    check_reset_values("rst_held");
    rst = 1'b0;
    tick(1);
    check_reset_values("after_rst");

    // Single-word loads from the table.
    for (int v = 0; v < 5; v++) begin
      mark = data_q.size();
      do_start(5'd1);
      send_byte(vecs[v].b0, 1'b0);
      send_byte(vecs[v].b1, 1'b0);
      send_byte(vecs[v].b2, 1'b0);
      send_byte(vecs[v].b3, 1'b0);
      byte_valid = 1'b0;
      tick(2);
      check($sformatf("vec%0d_pulses", v), 32'(data_q.size() - mark), 32'd1);
      if (data_q.size() > mark) begin
        check($sformatf("vec%0d_addr", v), addr_q[mark], 32'd0);
        check($sformatf("vec%0d_data", v), data_q[mark], vecs[v].exp_word);
        check($sformatf("vec%0d_chk_at_wr", v), chk_q[mark], vecs[v].exp_word);
      end
      check($sformatf("vec%0d_done", v), 32'(done), 32'd1);
      check($sformatf("vec%0d_checksum", v), checksum, vecs[v].exp_word);
    end

    // Back-to-back: three words with byte_valid held high throughout.
    tx_words[0] = 32'h1122_3344;
    tx_words[1] = 32'hA5A5_5A5A;
    tx_words[2] = 32'h0BAD_F00D;
    mark = data_q.size();
    do_start(5'd3);
    load_words(3, 1'b0, -1);
    tick(2);
    verify_session("b2b", mark, 3);

    // Gapped bytes on the first two of the same words.
    mark = data_q.size();
    do_start(5'd2);
    load_words(2, 1'b1, -1);
    tick(2);
    verify_session("gap", mark, 2);

    // Illegal lengths, then a legal start that clears err.
    mark = data_q.size();
    do_start(5'd0);
    check("len0_err",        32'(err),        32'd1);
    check("len0_done",       32'(done),       32'd0);
    check("len0_busy",       32'(busy),       32'd0);
    check("len0_byte_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'(8'h40 + i);
      tick(1);
    end
    byte_valid = 1'b0;
    do_start(5'd17);
    check("len17_err",  32'(err),  32'd1);
    check("len17_busy", 32'(busy), 32'd0);
    tick(2);
    check("illegal_no_wr", 32'(data_q.size() - mark), 32'd0);
    do_start(5'd1);
    check("legal_clears_err", 32'(err),  32'd0);
    check("legal_busy",       32'(busy), 32'd1);
    tx_words[0] = 32'h0BAD_F00D;
    mark = data_q.size();
    load_words(1, 1'b0, -1);
    tick(2);
    verify_session("legal", mark, 1);

    // Reset after two bytes of word 1, with a byte and start in the same cycle.
    tx_words[0] = 32'hC001_D00D;
    mark = data_q.size();
    do_start(5'd2);
    load_words(1, 1'b0, -1);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    rst = 1'b1; byte_valid = 1'b1; byte_in = 8'hEF; start = 1'b1; num_words = 5'd2;
    tick(1);
    rst = 1'b0; byte_valid = 1'b0; start = 1'b0;
    check_reset_values("midrst");
    tick(3);
    check("midrst_pulses", 32'(data_q.size() - mark), 32'd1);
    tx_words[0] = 32'hCAFE_F00D;
    mark = data_q.size();
    do_start(5'd1);
    load_words(1, 1'b0, -1);
    tick(2);
    verify_session("fresh", mark, 1);

    // Full-depth load with a start pulse mid-session.
    for (int i = 0; i < DEPTH; i++) tx_words[i] = $urandom;
    exp_xor = '0;
    for (int i = 0; i < DEPTH; i++) exp_xor = exp_xor ^ tx_words[i];
    mark = data_q.size();
    do_start(5'd16);
    load_words(DEPTH, 1'b0, 22);
    tick(2);
    verify_session("full", mark, DEPTH);
    check("full_xor", checksum, exp_xor);

    check("ready_never_dropped", 32'(ready_drops),   32'd0);
    check("single_cycle_wr_en",  32'(double_pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
